// File: rtl/mux81_rr_arbiter_pkg.sv
// Shared types and constants for the 8:1 mux round-robin arbiter.
// Requester count, select width, FSM state encoding and a one-hot helper.
package mux81_rr_arbiter_pkg;

   localparam int unsigned N     = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_GAP
   } state_t;

   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux81_rr_arbiter_if.sv
// Request/grant/mux-control bundle between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mux81_rr_arbiter_if;
   import mux81_rr_arbiter_pkg::*;

   logic [N-1:0]     Req_In;
   logic [N-1:0]     Grant_Out;
   logic [SEL_W-1:0] Sel_Out;
   logic             CSn_Out;
   logic             Busy_Out;

   modport master (
      output Req_In,
      input  Grant_Out,
      input  Sel_Out,
      input  CSn_Out,
      input  Busy_Out
   );

   modport slave (
      input  Req_In,
      output Grant_Out,
      output Sel_Out,
      output CSn_Out,
      output Busy_Out
   );

endinterface

// File: rtl/mux81_rr_arbiter_rr_pick8.sv
// Combinational round-robin winner search: first set request bit found
// scanning cyclically upward from ptr.
module rr_pick8
   import mux81_rr_arbiter_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             valid
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      idx   = ptr;
      valid = 1'b0;
      cand  = ptr;
      for (int unsigned k = 0; k < N; k++) begin
         cand = ptr + SEL_W'(k);
         if (!valid && req[cand]) begin
            idx   = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux81_rr_arbiter.sv
// 8:1 mux round-robin arbiter: IDLE/GRANT/GAP FSM with bounded hold time and
// a guaranteed one-cycle dead gap (CSn high) between consecutive owners.
module mux81_rr_arbiter
   import mux81_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
)(
   input  logic             clk,
   input  logic             rst,
   mux81_rr_arbiter_if.slave bus
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t           state_q;
   logic [SEL_W-1:0] ptr_q;
   logic [7:0]       cnt_q;
   logic [N-1:0]     grant_q;
   logic [SEL_W-1:0] sel_q;
   logic             csn_q;
   logic             busy_q;

   logic [SEL_W-1:0] win_idx;
   logic             win_valid;

   rr_pick8 u_pick (
      .req   (bus.Req_In),
      .ptr   (ptr_q),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         csn_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_GAP: begin
               if (win_valid) begin
                  state_q <= ST_GRANT;
                  grant_q <= onehot(win_idx);
                  sel_q   <= win_idx;
                  csn_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else if (state_q == ST_GAP) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_GRANT: begin
               // sel_q is the owner index for the whole grant; it also stays
               // frozen through GAP so the mux select never glitches.
               if (!bus.Req_In[sel_q] || cnt_q == HOLD_LAST) begin
                  state_q <= ST_GAP;
                  grant_q <= '0;
                  csn_q   <= 1'b1;
                  ptr_q   <= sel_q + SEL_W'(1);
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Grant_Out = grant_q;
   assign bus.Sel_Out   = sel_q;
   assign bus.CSn_Out   = csn_q;
   assign bus.Busy_Out  = busy_q;

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Directed bench for mux81_rr_arbiter: a behavioural model predicts each
// cycle's outputs into a scoreboard queue, popped and checked after the edge.
module tb_mux81_rr_arbiter;

   localparam int unsigned HOLD = 4;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       csn;
      logic       busy;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   exp_t sb[$];

   // model state: 0 idle, 1 grant, 2 gap
   int         m_st;
   int         m_ptr;
   int         m_cnt;
   int         m_sel;
   logic [7:0] m_grant;
   logic       m_csn;
   logic       m_busy;

   mux81_rr_arbiter_if bus();

   mux81_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic predict(input logic r, input logic [7:0] req);
      exp_t e;
      int   best_d;
      int   best_j;
      if (r) begin
         m_st = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
         m_grant = 8'h00; m_csn = 1'b1; m_busy = 1'b0;
      end else if (m_st == 1) begin
         if (req[m_sel] == 1'b0 || m_cnt == HOLD - 1) begin
            m_st = 2; m_grant = 8'h00; m_csn = 1'b1;
            m_ptr = (m_sel + 1) % 8;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end else begin
         best_d = 8;
         best_j = 0;
         for (int j = 0; j < 8; j++)
            if (req[j] && ((j - m_ptr + 8) % 8) < best_d) begin
               best_d = (j - m_ptr + 8) % 8;
               best_j = j;
            end
         if (best_d < 8) begin
            m_st = 1; m_sel = best_j; m_grant = 8'h01 << best_j;
            m_csn = 1'b0; m_busy = 1'b1; m_cnt = 0;
         end else if (m_st == 2) begin
            m_st = 0; m_busy = 1'b0;
         end
      end
      e.grant = m_grant;
      e.sel   = 3'(m_sel);
      e.csn   = m_csn;
      e.busy  = m_busy;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk("grant", bus.Grant_Out, e.grant);
         chk("sel", 8'(bus.Sel_Out), 8'(e.sel));
         chk("csn", 8'(bus.CSn_Out), 8'(e.csn));
         chk("busy", 8'(bus.Busy_Out), 8'(e.busy));
      end
      chk("inv_onehot0", 8'($onehot0(bus.Grant_Out)), 8'd1);
      chk("inv_csn", 8'(bus.CSn_Out), 8'(bus.Grant_Out == 8'h00));
      if (bus.CSn_Out == 1'b0)
         chk("inv_sel", bus.Grant_Out, 8'h01 << bus.Sel_Out);
   endtask

   task automatic step(input logic r, input logic [7:0] req);
      rst        = r;
      bus.Req_In = req;
      predict(r, req);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.Req_In = 8'h00;
      m_st = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
      m_grant = 8'h00; m_csn = 1'b1; m_busy = 1'b0;

      // reset with all requests high
      step(1'b1, 8'hFF);
      step(1'b1, 8'hFF);
      chk("rst_grant", bus.Grant_Out, 8'h00);
      chk("rst_csn", 8'(bus.CSn_Out), 8'd1);
      chk("rst_busy", 8'(bus.Busy_Out), 8'd0);

      // single owner held: 4 grant cycles, 1 gap, repeat
      for (int i = 0; i < 12; i++) step(1'b0, 8'h01);

      // wrap-around between requesters 0 and 7
      step(1'b1, 8'h00);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h81);

      // early release after 3 cycles
      step(1'b1, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h04);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
      chk("early_idle_busy", 8'(bus.Busy_Out), 8'd0);

      // reset in the middle of a grant to 3
      step(1'b0, 8'h08);
      step(1'b0, 8'h08);
      step(1'b1, 8'h08);
      chk("midrst_grant", bus.Grant_Out, 8'h00);
      step(1'b0, 8'h08);
      chk("midrst_regrant", bus.Grant_Out, 8'h08);
      chk("midrst_sel", 8'(bus.Sel_Out), 8'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

      // full load: owners 0..7 then 0 again
      step(1'b1, 8'h00);
      for (int i = 0; i < 45; i++) step(1'b0, 8'hFF);
      chk("full_wrap_sel", 8'(bus.Sel_Out), 8'd0);

      // non-contiguous requests with a mid-grant change
      step(1'b1, 8'h00);
      step(1'b0, 8'h24);
      step(1'b0, 8'h64);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h60);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
